// File: rtl/sar_sample_sink.sv
// Far-end consumer of the sar_control result interface: requests conversions with adc_en,
// buffers each load_reg result in a show-ahead FIFO and streams it out over valid/ready.
module sar_sample_sink #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [CNT_W-1:0]           num_samples,
    output logic                       adc_en,
    input  logic                       load_reg,
    input  logic [WIDTH-1:0]           reg_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           overflow_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    // Output stream handshake: a sample moves downstream on every clock edge where
    // out_valid and out_ready are both high; out_valid/out_data hold while stalled.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             adc_en_q, adc_en_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    logic             pop;
    logic             full;
    logic             capture;
    logic             push;
    logic             drop;
    logic             last_capture;

    always_comb begin
        pop          = (level_q != '0) && out_ready;
        full         = (level_q == LW'(DEPTH));
        capture      = (state_q == S_RUN) && load_reg;
        // A full FIFO still accepts a sample when the head leaves in the same cycle.
        push         = capture && (!full || pop);
        drop         = capture && !push;
        last_capture = capture && (CNT_W'(cap_cnt_q + CNT_W'(1)) == num_q);
    end

    always_comb begin
        state_d   = state_q;
        adc_en_d  = adc_en_q;
        done_d    = 1'b0;
        num_d     = num_q;
        cap_cnt_d = cap_cnt_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_samples != '0) begin
                        num_d     = num_samples;
                        cap_cnt_d = '0;
                        ovf_d     = '0;
                        adc_en_d  = 1'b1;
                        state_d   = S_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (capture) begin
                    cap_cnt_d = CNT_W'(cap_cnt_q + CNT_W'(1));
                end
                if (drop && (ovf_q != {CNT_W{1'b1}})) begin
                    ovf_d = CNT_W'(ovf_q + CNT_W'(1));
                end
                if (last_capture || abort) begin
                    adc_en_d = 1'b0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (level_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                adc_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            mem_d[wr_ptr_q] = reg_wdata;
            wr_ptr_d        = PW'(wr_ptr_q + PW'(1));
        end
        if (pop) begin
            rd_ptr_d = PW'(rd_ptr_q + PW'(1));
        end
        case ({push, pop})
            2'b10:   level_d = LW'(level_q + LW'(1));
            2'b01:   level_d = LW'(level_q - LW'(1));
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            adc_en_q  <= 1'b0;
            done_q    <= 1'b0;
            num_q     <= '0;
            cap_cnt_q <= '0;
            ovf_q     <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            adc_en_q  <= adc_en_d;
            done_q    <= done_d;
            num_q     <= num_d;
            cap_cnt_q <= cap_cnt_d;
            ovf_q     <= ovf_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    assign adc_en       = adc_en_q;
    assign done         = done_q;
    assign busy         = (state_q != S_IDLE);
    assign out_valid    = (level_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_sar_sample_sink.sv
// Self-checking bench for sar_sample_sink: directed scenarios plus a randomized run
// compared against a queue-based model of the burst/FIFO rules.
module tb_sar_sample_sink;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_samples;
    logic             adc_en;
    logic             load_reg;
    logic [WIDTH-1:0] reg_wdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    fifo_level;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] overflow_cnt;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_q[$];
    int               done_seen;

    bit m_cap;
    bit m_drain;
    int m_left;
    int m_ovf;
    bit m_done;

    sar_sample_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .num_samples  (num_samples),
        .adc_en       (adc_en),
        .load_reg     (load_reg),
        .reg_wdata    (reg_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .fifo_level   (fifo_level),
        .busy         (busy),
        .done         (done),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        exp_q.delete();
        m_cap   = 1'b0;
        m_drain = 1'b0;
        m_left  = 0;
        m_ovf   = 0;
        m_done  = 1'b0;
    endfunction

    // One clock of the burst rules, evaluated with the inputs present before the edge.
    function automatic void model_update();
        int               sz;
        bit               pop_now;
        bit               push_now;
        bit               done_now;
        logic [WIDTH-1:0] pd;
        sz       = exp_q.size();
        pop_now  = (sz > 0) && out_ready;
        push_now = 1'b0;
        done_now = 1'b0;
        pd       = '0;
        if (!m_cap && !m_drain) begin
            if (start) begin
                if (num_samples == 0) begin
                    done_now = 1'b1;
                end else begin
                    m_cap  = 1'b1;
                    m_left = int'(num_samples);
                    m_ovf  = 0;
                end
            end
        end else if (m_cap) begin
            if (load_reg) begin
                if (sz < DEPTH || pop_now) begin
                    push_now = 1'b1;
                    pd       = reg_wdata;
                end else if (m_ovf < 255) begin
                    m_ovf++;
                end
                m_left--;
                if (m_left == 0) begin
                    m_cap   = 1'b0;
                    m_drain = 1'b1;
                end
            end
            if (abort) begin
                m_cap   = 1'b0;
                m_drain = 1'b1;
            end
        end else if (sz == 0) begin
            m_drain  = 1'b0;
            done_now = 1'b1;
        end
        if (pop_now) void'(exp_q.pop_front());
        if (push_now) exp_q.push_back(pd);
        m_done = done_now;
    endfunction

    task automatic tick();
        if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
        if (done) done_seen++;
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (done_seen > 0) break;
            tick();
        end
        tick();
        tick();
    endtask

    task automatic begin_burst(input int n);
        got_q.delete();
        done_seen   = 0;
        start       = 1'b1;
        num_samples = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_samples = '0;
        load_reg = 1'b0; reg_wdata = '0; out_ready = 1'b0;
        model_reset();
        #2;
        tick(); tick(); tick();
        checks++;
        if ({adc_en, out_valid, busy, done} !== 4'b0 || out_data !== '0 ||
            fifo_level !== '0 || overflow_cnt !== '0) begin
            failures++;
            $display("FAIL reset_outputs: adc_en=%b out_valid=%b busy=%b done=%b out_data=%0d level=%0d ovf=%0d, expected all zero",
                     adc_en, out_valid, busy, done, out_data, fifo_level, overflow_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] seq[3];
        seq[0] = 3'd5; seq[1] = 3'd2; seq[2] = 3'd7;
        out_ready = 1'b1;
        begin_burst(3);
        checks++;
        if (adc_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_start: adc_en=%b busy=%b, expected 1 1", adc_en, busy);
        end
        for (int k = 0; k < 3; k++) begin
            load_reg = 1'b1; reg_wdata = seq[k];
            tick();
            load_reg = 1'b0;
            if (k == 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 3'd5) begin
                    failures++;
                    $display("FAIL basic_latency: out_valid=%b out_data=%0d, expected 1 5", out_valid, out_data);
                end
            end
            checks++;
            if (adc_en !== (k < 2)) begin
                failures++;
                $display("FAIL basic_adc_en capture %0d: adc_en=%b, expected %b", k, adc_en, (k < 2));
            end
            tick();
        end
        wait_done(20);
        checks++;
        if (done_seen !== 1) begin
            failures++;
            $display("FAIL basic_done: pulses=%0d, expected 1", done_seen);
        end
        checks++;
        if (got_q.size() != 3 || got_q[0] !== seq[0] || got_q[1] !== seq[1] || got_q[2] !== seq[2]) begin
            failures++;
            $display("FAIL basic_data: got %0d items %p, expected 5 2 7", got_q.size(), got_q);
        end
        checks++;
        if (overflow_cnt !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_end: ovf=%0d busy=%b, expected 0 0", overflow_cnt, busy);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        begin_burst(6);
        for (int d = 1; d <= 6; d++) begin
            load_reg = 1'b1; reg_wdata = WIDTH'(d);
            tick();
        end
        load_reg = 1'b0;
        checks++;
        if (fifo_level !== LW'(4) || overflow_cnt !== 8'd2 || adc_en !== 1'b0 || out_data !== 3'd1) begin
            failures++;
            $display("FAIL ovf_fill: level=%0d ovf=%0d adc_en=%b head=%0d, expected 4 2 0 1",
                     fifo_level, overflow_cnt, adc_en, out_data);
        end
        out_ready = 1'b1;
        wait_done(20);
        checks++;
        if (done_seen !== 1 || got_q.size() != 4 || got_q[0] !== 3'd1 || got_q[1] !== 3'd2 ||
            got_q[2] !== 3'd3 || got_q[3] !== 3'd4) begin
            failures++;
            $display("FAIL ovf_drain: done=%0d got %p, expected 1 pulse and 1 2 3 4", done_seen, got_q);
        end
        checks++;
        if (overflow_cnt !== 8'd2) begin
            failures++;
            $display("FAIL ovf_hold: ovf=%0d, expected 2", overflow_cnt);
        end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        begin_burst(5);
        for (int d = 1; d <= 4; d++) begin
            load_reg = 1'b1; reg_wdata = WIDTH'(d);
            tick();
        end
        out_ready = 1'b1; load_reg = 1'b1; reg_wdata = 3'd6;
        tick();
        load_reg = 1'b0;
        checks++;
        if (fifo_level !== LW'(4) || overflow_cnt !== '0 || out_data !== 3'd2 || adc_en !== 1'b0) begin
            failures++;
            $display("FAIL full_pop: level=%0d ovf=%0d head=%0d adc_en=%b, expected 4 0 2 0",
                     fifo_level, overflow_cnt, out_data, adc_en);
        end
        wait_done(20);
        checks++;
        if (done_seen !== 1 || got_q.size() != 5 || got_q[3] !== 3'd4 || got_q[4] !== 3'd6) begin
            failures++;
            $display("FAIL full_pop_drain: done=%0d got %p, expected 1 pulse and 1 2 3 4 6", done_seen, got_q);
        end
    endtask

    task automatic test_abort();
        out_ready = 1'b0;
        begin_burst(10);
        load_reg = 1'b1; reg_wdata = 3'd3; tick();
        reg_wdata = 3'd4; tick();
        load_reg = 1'b0; abort = 1'b1; tick();
        abort = 1'b0;
        checks++;
        if (adc_en !== 1'b0 || busy !== 1'b1 || fifo_level !== LW'(2)) begin
            failures++;
            $display("FAIL abort_edge: adc_en=%b busy=%b level=%0d, expected 0 1 2", adc_en, busy, fifo_level);
        end
        load_reg = 1'b1; reg_wdata = 3'd7;
        tick(); tick(); tick();
        load_reg = 1'b0;
        checks++;
        if (fifo_level !== LW'(2)) begin
            failures++;
            $display("FAIL abort_ignore: level=%0d, expected 2", fifo_level);
        end
        out_ready = 1'b1;
        wait_done(20);
        checks++;
        if (done_seen !== 1 || got_q.size() != 2 || got_q[0] !== 3'd3 || got_q[1] !== 3'd4) begin
            failures++;
            $display("FAIL abort_drain: done=%0d got %p, expected 1 pulse and 3 4", done_seen, got_q);
        end
    endtask

    task automatic test_zero_count();
        begin_burst(0);
        checks++;
        if (done !== 1'b1 || adc_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_start: done=%b adc_en=%b busy=%b, expected 1 0 0", done, adc_en, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || adc_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_after: done=%b adc_en=%b, expected 0 0", done, adc_en);
        end
    endtask

    task automatic test_start_busy();
        out_ready = 1'b1;
        begin_burst(2);
        tick();
        start = 1'b1; num_samples = 8'd9; tick();
        start = 1'b0;
        load_reg = 1'b1; reg_wdata = 3'd1; tick();
        checks++;
        if (adc_en !== 1'b1) begin
            failures++;
            $display("FAIL busy_start_mid: adc_en=%b, expected 1", adc_en);
        end
        tick();
        load_reg = 1'b0;
        checks++;
        if (adc_en !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_count: adc_en=%b, expected 0 after 2 captures", adc_en);
        end
        wait_done(20);
        checks++;
        if (done_seen !== 1) begin
            failures++;
            $display("FAIL busy_start_done: pulses=%0d, expected 1", done_seen);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        begin_burst(5);
        for (int d = 0; d < 3; d++) begin
            load_reg = 1'b1; reg_wdata = WIDTH'($urandom_range(1, 7));
            tick();
        end
        load_reg = 1'b0;
        checks++;
        if (fifo_level !== LW'(3) || adc_en !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup: level=%0d adc_en=%b, expected 3 1", fifo_level, adc_en);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({adc_en, out_valid, busy, done} !== 4'b0 || out_data !== '0 ||
            fifo_level !== '0 || overflow_cnt !== '0) begin
            failures++;
            $display("FAIL areset_outputs: adc_en=%b out_valid=%b busy=%b done=%b out_data=%0d level=%0d ovf=%0d, expected all zero",
                     adc_en, out_valid, busy, done, out_data, fifo_level, overflow_cnt);
        end
        model_reset();
        got_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        test_basic();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            start       = ($urandom_range(0, 7) == 0);
            num_samples = CNT_W'($urandom_range(0, 6));
            abort       = ($urandom_range(0, 29) == 0);
            load_reg    = $urandom_range(0, 1) == 1;
            reg_wdata   = WIDTH'($urandom_range(0, 7));
            out_ready   = ($urandom_range(0, 9) < 6);
            tick();
            checks++;
            if (adc_en !== m_cap || busy !== (m_cap || m_drain) || done !== m_done) begin
                failures++;
                $display("FAIL rand_ctrl cycle %0d: adc_en=%b busy=%b done=%b, expected %b %b %b",
                         c, adc_en, busy, done, m_cap, (m_cap || m_drain), m_done);
            end
            checks++;
            if (fifo_level !== LW'(exp_q.size()) || out_valid !== (exp_q.size() > 0) ||
                overflow_cnt !== CNT_W'(m_ovf)) begin
                failures++;
                $display("FAIL rand_fifo cycle %0d: level=%0d valid=%b ovf=%0d, expected %0d %b %0d",
                         c, fifo_level, out_valid, overflow_cnt, exp_q.size(), (exp_q.size() > 0), m_ovf);
            end
            if (exp_q.size() > 0) begin
                checks++;
                if (out_data !== exp_q[0]) begin
                    failures++;
                    $display("FAIL rand_data cycle %0d: out_data=%0d, expected %0d", c, out_data, exp_q[0]);
                end
            end
        end
        start = 1'b0; abort = 1'b0; load_reg = 1'b0;
    endtask

    initial begin
        done_seen = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_abort();
        test_zero_count();
        test_start_busy();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sar_sample_sink.md
Name: sar_sample_sink

Overview:
- Consumer and initiator at the far end of the sar_control result interface.
- Requests conversions by driving adc_en, captures each result presented on load_reg/reg_wdata into a small show-ahead FIFO, and hands samples downstream over a valid/ready stream.
- Runs bursts of a programmed sample count; tracks dropped samples; reports burst completion.

Parameters:
- WIDTH, 3, result width; matches sar_control WIDTH.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- CNT_W, 8, width of num_samples and the capture counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle burst request
- abort  input  1  single-cycle burst cancel
- num_samples  input  CNT_W  conversions per burst; sampled on an accepted start
- adc_en  output  1  conversion enable to sar_control
- load_reg  input  1  result-valid strobe from sar_control
- reg_wdata  input  WIDTH  conversion result from sar_control
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  downstream accept
- out_data  output  WIDTH  FIFO head, show-ahead
- fifo_level  output  $clog2(DEPTH+1)  current occupancy
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse at burst end
- overflow_cnt  output  CNT_W  dropped-sample count for the current burst; saturates at all-ones

Behaviour:
- Reset (asynchronous, rst_n=0) clears all state immediately: state=IDLE; adc_en, out_valid, busy, done = 0; out_data, fifo_level, overflow_cnt, capture counter = 0; FIFO pointers = 0. This applies mid-burst too, and FIFO contents are discarded.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with num_samples≠0: latch num_samples, clear capture counter and overflow_cnt, go to RUN. adc_en rises on that same clock edge, so it is high in the cycle after start.
  - start=1 with num_samples=0: stay in IDLE; done pulses in the next cycle; adc_en stays 0.
  - load_reg is ignored in IDLE and DRAIN: no push, no count.
- RUN:
  - adc_en=1.
  - Each cycle with load_reg=1 is one capture; the capture counter increments.
  - Push reg_wdata if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the sample and increment overflow_cnt (saturating).
  - When the capture that makes the count equal the latched num_samples occurs, adc_en clears on that edge and the state moves to DRAIN.
  - abort=1: adc_en clears on that edge and the state moves to DRAIN. If a capture occurs in the same cycle, it is still processed.
  - abort has priority over completion only in that both lead to DRAIN; there is no other difference.
  - start is ignored while busy.
- DRAIN:
  - adc_en=0.
  - When the FIFO is empty (fifo_level=0), done pulses for one cycle and the state returns to IDLE in the same cycle. done is registered, so it is high in the first cycle in which IDLE is visible.
  - If the FIFO is already empty on DRAIN entry, done pulses in the next cycle.
- Downstream stream:
  - out_valid = (fifo_level≠0); out_data = head entry. Both are registered/derived from pointers with no bubble.
  - A pop occurs when out_valid and out_ready are both 1.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0.
  - Push and pop may occur in the same cycle; fifo_level is then unchanged.
  - Push into an empty FIFO: out_valid rises in the next cycle (1-cycle capture latency).
  - Pointers wrap modulo DEPTH.
- overflow_cnt holds its value after the burst until the next accepted start.
- busy = (state≠IDLE).

Test Plan:
- Basic burst: start with num_samples=3, out_ready=1, load_reg pulses carrying 5, 2, 7 → adc_en high from the cycle after start until the 3rd capture edge; out_data sequence 5, 2, 7; done pulses once, after the last pop; overflow_cnt=0.
- Overflow: DEPTH=4, out_ready=0, num_samples=6, six captures of 1..6 → fifo_level=4, overflow_cnt=2. Then raise out_ready → out_data 1, 2, 3, 4; done follows the 4th pop.
- Full with simultaneous pop: FIFO full, out_ready=1, load_reg=1 with data 6 in the same cycle → sample accepted; fifo_level stays 4; overflow_cnt unchanged.
- Abort: num_samples=10, abort after 2 captures → adc_en=0 in the next cycle; further load_reg pulses are ignored; done pulses after 2 pops.
- Corner cases:
  - num_samples=0 start → done in the next cycle; adc_en never rises.
  - start while busy → no effect.
- Async reset mid-RUN with the FIFO holding 3 entries → all outputs 0 immediately, without waiting for a clock edge; a subsequent burst behaves as in the basic-burst case.
